calc2_port_arbiter: RTL and testbench

//  Shares one add/sub/shift ALU among the four calculator request ports.

---
 rtl/calc2_port_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_calc2_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_port_arbiter.sv
// Four-port request front end sharing one add/sub/shift ALU.
// Each port captures a two-cycle request; a round-robin arbiter issues it and routes the result back.
module calc2_port_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned TW      = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            c_clk,
    input  logic            reset,
    input  logic [15:0]     req_cmd_in,
    input  logic [4*DW-1:0] req_data_in,
    input  logic [4*TW-1:0] req_tag_in,
    output logic [7:0]      out_resp,
    output logic [4*DW-1:0] out_data,
    output logic [4*TW-1:0] out_tag,
    output logic            alu_valid,
    output logic [3:0]      alu_cmd,
    output logic [DW-1:0]   alu_op1,
    output logic [DW-1:0]   alu_op2,
    input  logic            alu_ready,
    input  logic            alu_done,
    input  logic [1:0]      alu_resp,
    input  logic [DW-1:0]   alu_result
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {PIdle, POp2, PPend} port_st_e;
    typedef enum logic [1:0] {AIdle, AIssue, AWait, AResp} arb_st_e;

    port_st_e        pst_q [4];
    port_st_e        pst_d [4];
    logic [3:0]      cmd_q [4];
    logic [3:0]      cmd_d [4];
    logic [DW-1:0]   op1_q [4];
    logic [DW-1:0]   op1_d [4];
    logic [DW-1:0]   op2_q [4];
    logic [DW-1:0]   op2_d [4];
    logic [TW-1:0]   tag_q [4];
    logic [TW-1:0]   tag_d [4];

    arb_st_e         ast_q, ast_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      res_resp_q, res_resp_d;
    logic [DW-1:0]   res_data_q, res_data_d;

    logic            alu_valid_q, alu_valid_d;
    logic [3:0]      alu_cmd_q, alu_cmd_d;
    logic [DW-1:0]   alu_op1_q, alu_op1_d;
    logic [DW-1:0]   alu_op2_q, alu_op2_d;
    logic [7:0]      out_resp_q, out_resp_d;
    logic [4*DW-1:0] out_data_q, out_data_d;
    logic [4*TW-1:0] out_tag_q, out_tag_d;

    logic            found;
    logic [1:0]      gsel;
    logic [1:0]      idx;

    function automatic logic cmd_valid(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            pst_d[p] = pst_q[p];
            cmd_d[p] = cmd_q[p];
            op1_d[p] = op1_q[p];
            op2_d[p] = op2_q[p];
            tag_d[p] = tag_q[p];
        end
        ast_d       = ast_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        res_resp_d  = res_resp_q;
        res_data_d  = res_data_q;
        alu_valid_d = alu_valid_q;
        alu_cmd_d   = alu_cmd_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        out_resp_d  = '0;
        out_data_d  = '0;
        out_tag_d   = '0;

        // Round-robin search: first pending port at or after rr_q.
        found = 1'b0;
        gsel  = rr_q;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && pst_q[idx] == PPend) begin
                found = 1'b1;
                gsel  = idx;
            end
        end

        for (int p = 0; p < 4; p++) begin
            case (pst_q[p])
                PIdle: begin
                    if (req_cmd_in[4*p +: 4] != 4'd0) begin
                        cmd_d[p] = req_cmd_in[4*p +: 4];
                        op1_d[p] = req_data_in[DW*p +: DW];
                        tag_d[p] = req_tag_in[TW*p +: TW];
                        pst_d[p] = POp2;
                    end
                end
                POp2: begin
                    op2_d[p] = req_data_in[DW*p +: DW];
                    if (cmd_valid(cmd_q[p])) begin
                        pst_d[p] = PPend;
                    end else begin
                        out_resp_d[2*p +: 2]   = 2'b10;
                        out_tag_d[TW*p +: TW] = tag_q[p];
                        pst_d[p]               = PIdle;
                    end
                end
                PPend: begin
                    if (ast_q == AResp && gnt_q == 2'(p)) begin
                        pst_d[p] = PIdle;
                    end
                end
                default: pst_d[p] = PIdle;
            endcase
        end

        case (ast_q)
            AIdle: begin
                if (found) begin
                    gnt_d       = gsel;
                    alu_valid_d = 1'b1;
                    alu_cmd_d   = cmd_q[gsel];
                    alu_op1_d   = op1_q[gsel];
                    alu_op2_d   = op2_q[gsel];
                    ast_d       = AIssue;
                end
            end
            AIssue: begin
                if (alu_ready) begin
                    alu_valid_d = 1'b0;
                    alu_cmd_d   = '0;
                    alu_op1_d   = '0;
                    alu_op2_d   = '0;
                    cnt_d       = '0;
                    ast_d       = AWait;
                end
            end
            AWait: begin
                if (alu_done) begin
                    res_resp_d = alu_resp;
                    res_data_d = alu_result;
                    ast_d      = AResp;
                end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                    res_resp_d = 2'b11;
                    res_data_d = '0;
                    ast_d      = AResp;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            AResp: begin
                out_resp_d[2*gnt_q +: 2]    = res_resp_q;
                out_data_d[DW*gnt_q +: DW]  = res_data_q;
                out_tag_d[TW*gnt_q +: TW]   = tag_q[gnt_q];
                rr_d                        = gnt_q + 2'd1;
                ast_d                       = AIdle;
            end
            default: ast_d = AIdle;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 4; p++) begin
                pst_q[p] <= PIdle;
                cmd_q[p] <= '0;
                op1_q[p] <= '0;
                op2_q[p] <= '0;
                tag_q[p] <= '0;
            end
            ast_q       <= AIdle;
            gnt_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            res_resp_q  <= '0;
            res_data_q  <= '0;
            alu_valid_q <= 1'b0;
            alu_cmd_q   <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            out_resp_q  <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                pst_q[p] <= pst_d[p];
                cmd_q[p] <= cmd_d[p];
                op1_q[p] <= op1_d[p];
                op2_q[p] <= op2_d[p];
                tag_q[p] <= tag_d[p];
            end
            ast_q       <= ast_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            res_resp_q  <= res_resp_d;
            res_data_q  <= res_data_d;
            alu_valid_q <= alu_valid_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            out_resp_q  <= out_resp_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_cmd   = alu_cmd_q;
    assign alu_op1   = alu_op1_q;
    assign alu_op2   = alu_op2_q;
    assign out_resp  = out_resp_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_calc2_port_arbiter.sv
// Directed bench for calc2_port_arbiter with a small reactive ALU model.
module tb_calc2_port_arbiter;

    localparam int DW = 32;
    localparam int TW = 2;

    logic            c_clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     req_cmd_in = '0;
    logic [4*DW-1:0] req_data_in = '0;
    logic [4*TW-1:0] req_tag_in = '0;
    logic [7:0]      out_resp;
    logic [4*DW-1:0] out_data;
    logic [4*TW-1:0] out_tag;
    logic            alu_valid;
    logic [3:0]      alu_cmd;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic            alu_ready = 1'b1;
    logic            alu_done = 1'b0;
    logic [1:0]      alu_resp = '0;
    logic [DW-1:0]   alu_result = '0;

    int n_checks = 0;
    int n_fail = 0;

    calc2_port_arbiter #(.DW(DW), .TW(TW), .TIMEOUT(16)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .alu_valid   (alu_valid),
        .alu_cmd     (alu_cmd),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_ready   (alu_ready),
        .alu_done    (alu_done),
        .alu_resp    (alu_resp),
        .alu_result  (alu_result)
    );

    always #5 c_clk = ~c_clk;

    // ALU model: done pulses m_lat cycles after the issue cycle; m_hang_once swallows one request.
    int          m_lat = 2;
    bit          m_hang_once = 1'b0;
    int          wait_cnt = 0;
    logic        m_acc;
    logic [3:0]  m_cmd;
    logic [31:0] m_op1, m_op2, pend_res;
    logic [31:0] op1_log[$];

    always @(posedge c_clk) begin
        m_acc = alu_valid & alu_ready;
        m_cmd = alu_cmd;
        m_op1 = alu_op1;
        m_op2 = alu_op2;
        #1;
        alu_done = 1'b0;
        if (m_acc) begin
            op1_log.push_back(m_op1);
            if (m_hang_once) begin
                m_hang_once = 1'b0;
            end else begin
                wait_cnt = m_lat;
                case (m_cmd)
                    4'd1:    pend_res = m_op1 + m_op2;
                    4'd2:    pend_res = m_op1 - m_op2;
                    4'd5:    pend_res = m_op1 << m_op2[4:0];
                    4'd6:    pend_res = m_op1 >> m_op2[4:0];
                    default: pend_res = 32'hdead_beef;
                endcase
            end
        end
        if (wait_cnt == 1) begin
            alu_done   = 1'b1;
            alu_resp   = 2'b01;
            alu_result = pend_res;
            wait_cnt   = 0;
        end else if (wait_cnt > 1) begin
            wait_cnt = wait_cnt - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] cmd, input logic [31:0] d,
                            input logic [1:0] tag);
        req_cmd_in[4*p +: 4]   = cmd;
        req_data_in[32*p +: 32] = d;
        req_tag_in[2*p +: 2]   = tag;
    endtask

    int          r_cnt [4];
    logic [1:0]  r_resp [4];
    logic [31:0] r_data [4];
    logic [1:0]  r_tag [4];

    task automatic collect(input int cycles);
        for (int p = 0; p < 4; p++) begin
            r_cnt[p] = 0; r_resp[p] = '0; r_data[p] = '0; r_tag[p] = '0;
        end
        repeat (cycles) begin
            tick();
            for (int p = 0; p < 4; p++) begin
                if (out_resp[2*p +: 2] != 2'b00) begin
                    r_cnt[p]++;
                    r_resp[p] = out_resp[2*p +: 2];
                    r_data[p] = out_data[32*p +: 32];
                    r_tag[p]  = out_tag[2*p +: 2];
                end
            end
        end
    endtask

    task automatic check_port(input string tag, input int p, input logic [1:0] resp,
                              input logic [31:0] data, input logic [1:0] t);
        check_eq({tag, "_cnt"}, 128'(r_cnt[p]), 128'd1);
        check_eq({tag, "_resp"}, 128'(r_resp[p]), 128'(resp));
        check_eq({tag, "_data"}, 128'(r_data[p]), 128'(data));
        check_eq({tag, "_tag"}, 128'(r_tag[p]), 128'(t));
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int  base;
    bit  vflag;

    initial begin
        #1 reset = 1'b0;
        #1;
        check_eq("rst_out_resp", 128'(out_resp), 128'd0);
        check_eq("rst_alu_valid", 128'(alu_valid), 128'd0);
        check_eq("rst_out_data", out_data, 128'd0);
        check_eq("rst_out_tag", 128'(out_tag), 128'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();

        // Single add on port 0, exact latency.
        set_port(0, 4'd1, 32'h30, 2'd1);
        tick();
        set_port(0, 4'd0, 32'h20, 2'd0);
        tick();
        req_data_in = '0;
        check_eq("t2_no_early_resp", 128'(out_resp), 128'd0);
        tick();
        check_eq("t2_alu_valid", 128'(alu_valid), 128'd1);
        check_eq("t2_alu_cmd", 128'(alu_cmd), 128'd1);
        check_eq("t2_alu_op1", 128'(alu_op1), 128'h30);
        check_eq("t2_alu_op2", 128'(alu_op2), 128'h20);
        tick(); tick(); tick();
        check_eq("t2_resp_not_yet", 128'(out_resp), 128'd0);
        tick();
        check_eq("t2_resp", 128'(out_resp), 128'h01);
        check_eq("t2_data", out_data, 128'h50);
        check_eq("t2_tag", 128'(out_tag), 128'h01);
        tick();
        check_eq("t2_resp_one_cycle", 128'(out_resp), 128'd0);

        // Reset asserted mid-stream while alu_valid is high.
        set_port(0, 4'd2, 32'h9, 2'd0);
        tick();
        set_port(0, 4'd0, 32'h1, 2'd0);
        tick();
        req_data_in = '0;
        tick();
        check_eq("t1_pre_valid", 128'(alu_valid), 128'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("t1_async_valid", 128'(alu_valid), 128'd0);
        check_eq("t1_async_op1", 128'(alu_op1), 128'd0);
        check_eq("t1_async_cmd", 128'(alu_cmd), 128'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        base = op1_log.size();
        collect(10);
        check_eq("t1_no_resp", 128'(r_cnt[0]), 128'd0);
        check_eq("t1_valid_after", 128'(alu_valid), 128'd0);
        check_eq("t1_no_issue", 128'(op1_log.size()), 128'(base));

        // All four ports shift left together: grants 0,1,2,3.
        base = op1_log.size();
        for (int p = 0; p < 4; p++) set_port(p, 4'd5, 32'(p + 1), 2'(p));
        tick();
        for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'(p + 1), 2'd0);
        tick();
        req_data_in = '0;
        collect(40);
        check_port("t3_p0", 0, 2'b01, 32'd2, 2'd0);
        check_port("t3_p1", 1, 2'b01, 32'd8, 2'd1);
        check_port("t3_p2", 2, 2'b01, 32'd24, 2'd2);
        check_port("t3_p3", 3, 2'b01, 32'd64, 2'd3);
        check_eq("t3_log_len", 128'(op1_log.size()), 128'(base + 4));
        for (int i = 0; i < 4; i++) check_eq("t3_order", 128'(op1_log[base + i]), 128'(i + 1));

        // Ports 2 and 0 together after rr wrapped to 0: grant 0 then 2.
        base = op1_log.size();
        set_port(0, 4'd1, 32'd5, 2'd3);
        set_port(2, 4'd6, 32'h80, 2'd1);
        tick();
        set_port(0, 4'd0, 32'd6, 2'd0);
        set_port(2, 4'd0, 32'd3, 2'd0);
        tick();
        req_data_in = '0;
        collect(25);
        check_port("t3b_p0", 0, 2'b01, 32'd11, 2'd3);
        check_port("t3b_p2", 2, 2'b01, 32'h10, 2'd1);
        check_eq("t3b_first", 128'(op1_log[base]), 128'd5);
        check_eq("t3b_second", 128'(op1_log[base + 1]), 128'h80);

        // Invalid command on port 1.
        set_port(1, 4'h3, 32'h55, 2'd2);
        tick();
        set_port(1, 4'd0, 32'h77, 2'd0);
        tick();
        req_data_in = '0;
        check_eq("t4_resp", 128'(out_resp), 128'h08);
        check_eq("t4_tag", 128'(out_tag), 128'h08);
        check_eq("t4_data", out_data, 128'd0);
        base = op1_log.size();
        tick();
        check_eq("t4_one_cycle", 128'(out_resp), 128'd0);
        vflag = 1'b0;
        repeat (6) begin
            tick();
            if (alu_valid) vflag = 1'b1;
        end
        check_eq("t4_no_valid", 128'(vflag), 128'd0);
        check_eq("t4_no_issue", 128'(op1_log.size()), 128'(base));

        // Timeout on port 0; port 1 queued behind it.
        m_hang_once = 1'b1;
        set_port(0, 4'd1, 32'd1, 2'd2);
        set_port(1, 4'd1, 32'd2, 2'd3);
        tick();
        set_port(0, 4'd0, 32'd1, 2'd0);
        set_port(1, 4'd0, 32'd3, 2'd0);
        tick();
        req_data_in = '0;
        repeat (18) tick();
        check_eq("t5_not_yet", 128'(out_resp), 128'd0);
        tick();
        check_eq("t5_timeout_resp", 128'(out_resp), 128'h03);
        check_eq("t5_timeout_data", out_data, 128'd0);
        check_eq("t5_timeout_tag", 128'(out_tag), 128'h02);
        collect(20);
        check_port("t5_p1", 1, 2'b01, 32'd5, 2'd3);

        // Reset during WAIT, then a late alu_done must be ignored.
        m_lat = 8;
        set_port(2, 4'd2, 32'h100, 2'd1);
        tick();
        set_port(2, 4'd0, 32'h1, 2'd0);
        tick();
        req_data_in = '0;
        tick(); tick(); tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        collect(12);
        check_eq("t6_no_resp", 128'(r_cnt[0] + r_cnt[1] + r_cnt[2] + r_cnt[3]), 128'd0);
        m_lat = 2;
        set_port(3, 4'd2, 32'h10, 2'd2);
        tick();
        set_port(3, 4'd0, 32'h4, 2'd0);
        tick();
        req_data_in = '0;
        collect(15);
        check_port("t6_p3", 3, 2'b01, 32'hC, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
